// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake into the UART transmitter: the producer drives
// in_data/in_valid, and the transmitter answers with in_ready.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small byte FIFO in front of it.
// Bytes are accepted on a valid/ready handshake, queued, and serialised
// LSB-first with one start and one stop bit, DELAY_FRAMES clocks per bit.
// The line output is registered one cycle behind the FSM state, so it is
// glitch-free and every bit cell is exactly DELAY_FRAMES clocks long.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_if.slave                 in_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DELAY_FRAMES + 1);

  localparam logic [BW-1:0] BAUD_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(DELAY_FRAMES);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e        state_q,   state_d;
  logic [BW-1:0] baud_q,    baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic          tx_q,      tx_d;
  logic          busy_q,    busy_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0] count_q,   count_d;
  logic          full_q,    full_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          fifo_nonempty_s;
  logic          baud_last_s;

  // in_ready comes straight from the full flop, so there is no path from in_valid
  assign push_s          = in_if.in_valid & ~full_q;
  assign fifo_nonempty_s = (count_q != COUNT_ZERO);
  assign baud_last_s     = (baud_q == BAUD_LAST);

  assign in_if.in_ready = ~full_q;
  assign uart_tx        = tx_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;

  // Transmit FSM: next state, baud/bit counters, shift register load and pop request
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_nonempty_s) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
          baud_d  = BAUD_ONE;
        end else begin
          baud_d  = BAUD_ZERO;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          baud_d    = BAUD_ONE;
        end else begin
          baud_d    = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_d = BAUD_ONE;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          // Chain straight into the next start bit when more data is queued
          if (fifo_nonempty_s) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
            baud_d  = BAUD_ONE;
          end else begin
            state_d = ST_IDLE;
            baud_d  = BAUD_ZERO;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_ZERO;
      end
    endcase
  end

  // Line level for the current state; registered below so uart_tx trails the state by one clock
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[bit_idx_q];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy, full flag and busy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == COUNT_FULL);
    busy_d = (state_d != ST_IDLE) || (count_d != COUNT_ZERO);
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_if.in_data;
    end
  end

  // State and control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= BAUD_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= COUNT_ZERO;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DELAY_FRAMES=4, FIFO_DEPTH=4.
// A line monitor decodes every frame from uart_tx and compares it, bit cell
// by bit cell, with the frame built from the next byte in a queue of bytes
// the bench saw accepted. Directed steps check latency, busy timing,
// back-to-back continuity, full/stall behaviour and reset mid-frame.
module tb_uart_tx_fifo;

  localparam int DF    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .DELAY_FRAMES(DF),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         frames_done = 0;
  logic [7:0] exp_q[$];

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line samples for one frame: DF clocks each of start, 8 data LSB-first, stop
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    logic [9:0]  cells;
    cells = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * DF; i++) f[i] = cells[i / DF];
    return f;
  endfunction

  // Line monitor: on a low level seen outside a frame, collect one full frame and score it
  initial begin : line_monitor
    logic [39:0] obs;
    logic [7:0]  b;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        obs     = '0;
        obs[0]  = uart_tx;
        aborted = 1'b0;
        for (int s = 1; s < 10 * DF; s++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          obs[s] = uart_tx;
        end
        if (!aborted) begin
          check("frame_has_byte", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("frame_bits", obs, frame_bits(b));
          end
          frames_done++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    logic rdy;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    rdy = bus.in_ready;
    @(posedge clk);
    if (rdy) exp_q.push_back(b);
    #1;
    bus.in_valid = 1'b0;
    check("push_ready", rdy, 1);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 3000 && frames_done < target; i++) @(posedge clk);
    #1;
    check("frames_done", frames_done, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy !== 1'b0; i++) begin
      @(posedge clk);
      #1;
    end
    check("idle", busy, 0);
  endtask

  initial begin : stimulus
    logic [79:0] line;
    int          cnt;
    int          accepted;
    int          lows;
    bit          stall_seen;
    logic        rdy;

    rst_n        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tx", uart_tx, 1);

    // 1: single 0x55, start bit two edges after the push, busy falls 40 clocks after the pop
    push(8'h55);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_busy_after_push", busy, 1);
    @(posedge clk); #1;
    check("t1_count_after_pop", fifo_count, 0);
    check("t1_tx_before_start", uart_tx, 1);
    @(posedge clk); #1;
    check("t1_start_latency", uart_tx, 0);
    cnt = 2;
    while (busy === 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("t1_busy_fall_edge", cnt, 41);
    check("t1_tx_after_frame", uart_tx, 1);
    wait_frames(1);
    wait_idle();

    // 2: back-to-back 0x00, 0xFF with no gap between frames
    push(8'h00);
    push(8'hFF);
    check("t2_count_push_pop", fifo_count, 1);
    @(posedge clk); #1;
    line    = '0;
    line[0] = uart_tx;
    for (int s = 1; s < 20 * DF; s++) begin
      @(posedge clk); #1;
      line[s] = uart_tx;
    end
    check("t2_continuous_line", line, {frame_bits(8'hFF), frame_bits(8'h00)});
    wait_frames(3);
    wait_idle();

    // 3: six random bytes with in_valid held high; stall at fifo_count=4
    accepted     = 0;
    stall_seen   = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && accepted < 6; cyc++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(bus.in_data);
        accepted++;
      end
      #1;
      if (rdy) bus.in_data = 8'($urandom);
      if (!bus.in_ready && !stall_seen) begin
        stall_seen = 1'b1;
        check("t3_full_count", fifo_count, 4);
        check("t3_accepted_at_full", accepted, 5);
      end
    end
    bus.in_valid = 1'b0;
    check("t3_accepted_total", accepted, 6);
    check("t3_stall_seen", stall_seen, 1);
    wait_frames(9);
    wait_idle();

    // 4: push on the same edge as the STOP->START pop with two entries queued
    push(8'h81);
    push(8'h42);
    push(8'h3C);
    repeat (38) @(posedge clk);
    #1;
    check("t4_count_before", fifo_count, 2);
    check("t4_tx_in_stop", uart_tx, 1);
    push(8'hE7);
    check("t4_count_push_pop", fifo_count, 2);
    @(posedge clk); #1;
    check("t4_no_gap_start", uart_tx, 0);
    wait_frames(13);
    wait_idle();

    // 5: reset during the data bits of 0xA5 truncates the frame and empties the FIFO
    push(8'hA5);
    push(8'h3C);
    repeat (10) @(posedge clk);
    #1;
    check("t5_tx_mid_data", uart_tx, 0);
    check("t5_count_mid_data", fifo_count, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_tx", uart_tx, 1);
    check("t5_async_count", fifo_count, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    lows = 0;
    for (int s = 0; s < 60; s++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_line_idle_after", lows, 0);
    check("t5_busy_after", busy, 0);
    check("t5_no_frame", frames_done, 13);

    // 6: random bytes with random valid gaps, checked by the line monitor
    accepted = 0;
    for (int cyc = 0; cyc < 3000 && accepted < 12; cyc++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = 8'($urandom);
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) begin
        exp_q.push_back(bus.in_data);
        accepted++;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    check("t6_accepted", accepted, 12);
    wait_frames(25);
    wait_idle();
    check("end_queue_empty", exp_q.size(), 0);
    check("end_count", fifo_count, 0);
    check("end_tx", uart_tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
